pipe_rca_add: RTL
=================

Name: pipe_rca_add

Overview:
- Parametrised, pipelined ripple-carry adder; next generation of the 4-bit combinational adder.
- Splits a WIDTH-bit add into STAGES equal slices, one slice per pipeline stage; the carry is registered between stages.
- Valid/ready streaming on both sides; accepts one operation per cycle; sits on datapath operand buses that need a clean WIDTH-wide add at full clock rate.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline stages; slice width SW = WIDTH/STAGES; STAGES >= 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB.
- overflow  output  1  signed overflow flag (carry into MSB xor carry out of MSB).

Behaviour:
- Stage k (0..STAGES-1) adds slice k of a and b, [k*SW +: SW], with the carry from stage k-1; stage 0 uses cin.
- Each stage registers:
  - its sum slice;
  - its carry-out;
  - the not-yet-consumed upper operand slices;
  - the lower sum slices already computed;
  - a valid bit.
- Global advance enable: adv = !out_valid || out_ready; in_ready = adv (combinational).
- When adv = 1, every stage register loads from its predecessor; stage 0 loads {a, b, cin, in_valid}.
- When adv = 0, all stages hold. Bubbles are not collapsed.
- A beat is accepted when in_valid && in_ready.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall; throughput 1/cycle.
- Output transfer occurs when out_valid && out_ready. sum/cout/overflow stay stable while out_valid && !out_ready.
- Ordering: results leave in acceptance order; none dropped or duplicated under any out_ready pattern.
- Overflow is computed in the last stage from the carry into bit WIDTH-1 and cout.
- Width rule: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
- Reset (reset = 0, asynchronous):
  - all valid bits, data and carry registers clear to 0;
  - out_valid = 0, sum = 0, cout = 0, overflow = 0 immediately;
  - in-flight operations are discarded.
- After reset deassertion, in_ready = 1 (since out_valid = 0).
- STAGES = 1: single registered adder, latency 1.
- in_valid held with in_ready = 0: the beat is not taken; the upstream holder keeps it.
- Simultaneous output transfer and input accept in the same cycle is legal and keeps full throughput.

Optional Feature:
- Macro: RCA_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured with the operands at acceptance and carried down the pipe with its beat.
  - sub = 1: the block computes a + ~b + ~cin, i.e. a - b - cin (cin acts as borrow-in).
  - cout is the raw carry: 1 = no borrow.
  - overflow uses the same rule on the inverted-b add.
  - sub = 0: identical to plain add.
- Not defined: sub port absent; add only; no inversion logic present.

Test Plan:
- Reset release, idle -> out_valid = 0, sum = 0, cout = 0, overflow = 0; in_ready = 1 one cycle after release.
- WIDTH = 16, STAGES = 4, out_ready = 1; a = 0x1234, b = 0x4321, cin = 0 accepted at cycle T -> at T+4: out_valid = 1, sum = 0x5555, cout = 0, overflow = 0.
- Carry chain across all slices: a = 0xFFFF, b = 0x0001, cin = 0 -> sum = 0x0000, cout = 1, overflow = 0. Also a = 0x7FFF, b = 0x0001 -> sum = 0x8000, cout = 0, overflow = 1.
- Stream of 8 back-to-back beats (a = i, b = 0x00F0*i, cin = i[0]) with out_ready low on cycles 5–7 -> in_ready low for exactly those cycles; all 8 results appear in order with correct values; sum is held stable during the stall.
- Reset asserted mid-stream with 3 beats in flight -> out_valid drops to 0 asynchronously; after release, no stale result appears before a new accepted beat emerges 4 cycles later.
- RCA_SUB_EN defined: a = 0x0005, b = 0x0007, cin = 0, sub = 1 -> sum = 0xFFFE, cout = 0, overflow = 0. Also a = 0x8000, b = 0x0001, sub = 1 -> sum = 0x7FFF, cout = 1, overflow = 1.

Source files
------------

// File: rtl/pipe_rca_add.sv
// pipe_rca_add: WIDTH-bit ripple-carry adder split into STAGES registered slices, valid/ready on both sides.
// Define RCA_SUB_EN to add a per-beat 'sub' input that turns the operation into a - b - cin.
module pipe_rca_add #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SW = WIDTH / STAGES;

  // *_d: what stage k consumes (ports for stage 0, previous register otherwise); *_q: stage k's register
  logic [STAGES-1:0] v_d, c_d, c_nxt, v_q, c_q;
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  s_d   [STAGES];
  logic [WIDTH-1:0]  s_nxt [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  s_q   [STAGES];
`ifdef RCA_SUB_EN
  logic              sub_d [STAGES];
  logic              sub_q [STAGES];
`endif
  logic              ovf_nxt;
  logic              ovf_q;
  logic              adv;

  // One global enable: the whole pipe moves or the whole pipe holds, bubbles included.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]    a_sl;
    logic [SW-1:0]    b_sl;
    logic [SW:0]      slice;
    logic [WIDTH-1:0] s_ins;

    if (k == 0) begin : g_head
      assign a_d[k] = a;
      assign b_d[k] = b;
      assign s_d[k] = '0;
      assign v_d[k] = in_valid;
`ifdef RCA_SUB_EN
      // Borrow-in: a - b - cin == a + ~b + ~cin.
      assign c_d[k]   = cin ^ sub;
      assign sub_d[k] = sub;
`else
      assign c_d[k] = cin;
`endif
    end else begin : g_link
      assign a_d[k] = a_q[k-1];
      assign b_d[k] = b_q[k-1];
      assign s_d[k] = s_q[k-1];
      assign v_d[k] = v_q[k-1];
      assign c_d[k] = c_q[k-1];
`ifdef RCA_SUB_EN
      assign sub_d[k] = sub_q[k-1];
`endif
    end

    assign a_sl = a_d[k][k*SW +: SW];
`ifdef RCA_SUB_EN
    assign b_sl = b_d[k][k*SW +: SW] ^ {SW{sub_d[k]}};
`else
    assign b_sl = b_d[k][k*SW +: SW];
`endif
    assign slice = {1'b0, a_sl} + {1'b0, b_sl} + {{SW{1'b0}}, c_d[k]};

    always_comb begin
      s_ins                = s_d[k];
      s_ins[k*SW +: SW]    = slice[SW-1:0];
    end

    assign s_nxt[k] = s_ins;
    assign c_nxt[k] = slice[SW];

    if (k == STAGES - 1) begin : g_tail
      // Carry into the MSB is recovered from the MSB's own sum bit and operand bits.
      assign ovf_nxt = (a_sl[SW-1] ^ b_sl[SW-1] ^ slice[SW-1]) ^ slice[SW];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's
  // pre-edge value; blocking here would let a beat fall through several stages in one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the per-stage data arrays are reset along with the valid bits so no stale operand or
      // sum ever reaches the outputs; the arrays are small registers, not RAM, so this is cheap.
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
`ifdef RCA_SUB_EN
        sub_q[k] <= 1'b0;
`endif
      end
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_nxt[k];
`ifdef RCA_SUB_EN
        sub_q[k] <= sub_d[k];
`endif
      end
      v_q   <= v_d;
      c_q   <= c_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule
